clock_phase_meter: RTL and testbench
====================================

// Module: clock_phase_meter
// PURPOSE
//  Receive-side companion to the clock phaser: measures the delay, in clk cycles, between the
//  rising edges of a reference waveform and its delayed copy. Reports each measurement and
//  declares lock once consecutive measurements agree. Sits next to the phaser output for
//  on-chip self-check of the programmed phase offset.
// PARAMETERS
//  CNT_W    8    width of delay counter and phase_cnt
//  MAX_CNT  200  timeout limit in clk cycles; MAX_CNT < 2**CNT_W required
//  LOCK_N   4    consecutive in-tolerance measurements required to assert locked (>=1)
//  TOL      1    max |new - previous| counted as agreeing, in clk cycles
// PORTS
//  clk          in   1      single clock, all logic rising-edge
//  reset        in   1      synchronous, active-high
//  enable       in   1      1 = measure; 0 = return to IDLE, clear state
//  ref_in       in   1      reference waveform, synchronous to clk
//  dly_in       in   1      delayed copy of ref_in, synchronous to clk
//  phase_cnt    out  CNT_W  last reported delay in clk cycles
//  meas_valid   out  1      1-cycle pulse: phase_cnt updated
//  timeout      out  1      1-cycle pulse: no dly edge within MAX_CNT cycles
//  locked       out  1      level: LOCK_N consecutive agreeing measurements
// BEHAVIOUR
//  - Reset: ref_q/dly_q=0, state=IDLE, cnt=0, phase_cnt=0, meas_valid=0, timeout=0, locked=0, match=0.
//  - No internal synchronisers; ref_in/dly_in are clk-domain signals.
//  - Edge detect: ref_rise = ref_in & ~ref_q; dly_rise = dly_in & ~dly_q.
//  - enable=0 in any state: next cycle state=IDLE, cnt=0, match=0, locked=0; phase_cnt held.
//  - IDLE: enable=1 -> WAIT_REF (edges in that cycle ignored).
//  - WAIT_REF: ref_rise & dly_rise same cycle -> result 0, stay WAIT_REF;
//    ref_rise only -> COUNT with cnt=1; dly_rise only -> ignored.
//  - COUNT: each cycle cnt++ (result = cycles from ref_rise cycle to dly_rise cycle):
//    dly_rise -> result=cnt, -> WAIT_REF; a simultaneous ref_rise is ignored (priority to completion).
//    ref_rise w/o dly_rise -> restart, cnt=1, stay COUNT, no result.
//    cnt==MAX_CNT w/o dly_rise -> timeout pulse, match=0, locked=0, phase_cnt held, -> WAIT_REF.
//  - Result: phase_cnt registered with meas_valid high in the cycle after dly_rise (1-cycle latency).
//  - Lock: first result after IDLE/timeout seeds prev, match=1; later |result-prev|<=TOL -> match++
//    (saturates at LOCK_N), else match=1; prev=result; locked = (match>=LOCK_N), updated with
//    meas_valid. Difference computed unsigned, CNT_W+1 bits, no wrap.
//  - Reset mid-measurement: abandoned, no pulses, all outputs back to reset values next cycle.
// CONFIGURATION
//  PHASE_AVG_EN defined: phase_cnt = floor(sum of last 4 results / 4), CNT_W+2-bit sum;
//    meas_valid suppressed until 4 results collected since IDLE/timeout (history cleared there);
//    lock compare still uses raw results.
//  PHASE_AVG_EN undefined: phase_cnt = raw result; meas_valid on every result. No averaging regs.
// TESTING
//  1. reset high 2 cycles, then enable=1, ref period 20, dly = ref delayed 3 cycles ->
//     phase_cnt=3, meas_valid 1 cycle after each dly edge, locked=1 after 4th result.
//  2. dly edge same cycle as ref edge -> phase_cnt=0, meas_valid pulses, no timeout.
//  3. ref toggling, dly held 0 -> timeout pulse at cnt=200, locked=0, phase_cnt unchanged.
//  4. locked at delay 3, delay jumps to 6 -> phase_cnt=6, locked drops same cycle,
//     re-asserts after 3 more results of 6; delay 3->4 (within TOL) keeps locked=1.
//  5. reset asserted mid-COUNT and enable=0 mid-COUNT -> all outputs 0 (enable=0 keeps phase_cnt),
//     no meas_valid; next measurement after re-enable correct.
//  6. PHASE_AVG_EN: results 4,4,4,8 -> first meas_valid on 4th result, phase_cnt=5.

Source files
------------

// File: rtl/clock_phase_meter.sv
// -----------------------------------------------------------------------------
// clock_phase_meter
//   Measures the delay, in clk cycles, from each rising edge of a reference
//   waveform to the next rising edge of its delayed copy. Every completed
//   measurement is reported on phase_cnt with a one-cycle meas_valid pulse.
//   locked is asserted once LOCK_N consecutive measurements agree within TOL.
//
//   Optional build macro: PHASE_AVG_EN
//     defined   : phase_cnt reports the floor mean of the last 4 results, and
//                 meas_valid stays low until 4 results have been collected.
//     undefined : phase_cnt reports every raw result.
//
// Ports
//   clk        in   rising-edge clock for all logic
//   reset      in   synchronous, active-high
//   enable     in   1 = measure, 0 = return to IDLE and clear lock state
//   ref_in     in   reference waveform (clk domain)
//   dly_in     in   delayed copy of ref_in (clk domain)
//   phase_cnt  out  last reported delay in clk cycles
//   meas_valid out  1-cycle pulse, phase_cnt updated
//   timeout    out  1-cycle pulse, no dly edge within MAX_CNT cycles
//   locked     out  LOCK_N consecutive agreeing measurements
// -----------------------------------------------------------------------------
module clock_phase_meter #(
  parameter int CNT_W   = 8,
  parameter int MAX_CNT = 200,
  parameter int LOCK_N  = 4,
  parameter int TOL     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             dly_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_N);
  localparam logic [CNT_W:0]   TOL_D  = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CNT);

  typedef enum logic [1:0] {IDLE, WAIT_REF, COUNT} state_t;

  state_t           state;
  logic             ref_q, dly_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev;
  logic [MW-1:0]    match;

  logic             ref_rise, dly_rise;
  logic             res_valid;
  logic [CNT_W-1:0] res_val;
  logic [CNT_W:0]   diff;
  logic [MW-1:0]    match_nxt;

  assign ref_rise = ref_in & ~ref_q;
  assign dly_rise = dly_in & ~dly_q;

  // Result of the current cycle. A dly edge completing a COUNT wins over a
  // coincident ref edge; coincident edges while waiting mean zero delay.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res_valid = 1'b0;
    res_val   = '0;
    if (state == WAIT_REF && ref_rise && dly_rise) begin
      res_valid = 1'b1;
    end else if (state == COUNT && dly_rise) begin
      res_valid = 1'b1;
      res_val   = cnt;
    end
  end

  // Lock bookkeeping: match == 0 means no previous result to compare with.
  always_comb begin
    if ({1'b0, res_val} >= {1'b0, prev}) diff = {1'b0, res_val} - {1'b0, prev};
    else                                 diff = {1'b0, prev} - {1'b0, res_val};
    if (match == '0)         match_nxt = MW'(1);
    else if (diff <= TOL_D)  match_nxt = (match >= LOCK_M) ? LOCK_M : match + MW'(1);
    else                     match_nxt = MW'(1);
  end

`ifdef PHASE_AVG_EN
  logic [CNT_W-1:0] hist [3];
  logic [1:0]       hist_n;
  logic [CNT_W+1:0] sum;
  logic [CNT_W-1:0] avg;

  always_comb begin
    sum = {2'b00, res_val} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    avg = CNT_W'(sum >> 2);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q      <= 1'b0;
      dly_q      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      prev       <= '0;
      match      <= '0;
      phase_cnt  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
`ifdef PHASE_AVG_EN
      hist_n     <= '0;
`endif
    end else begin
      ref_q      <= ref_in;
      dly_q      <= dly_in;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        match  <= '0;
        locked <= 1'b0;
`ifdef PHASE_AVG_EN
        hist_n <= '0;
`endif
      end else begin
        case (state)
          IDLE: state <= WAIT_REF;
          WAIT_REF: begin
            if (ref_rise && !dly_rise) begin
              state <= COUNT;
              cnt   <= CNT_W'(1);
            end
          end
          COUNT: begin
            if (dly_rise) begin
              state <= WAIT_REF;
              cnt   <= '0;
            end else if (cnt == MAX_C) begin
              timeout <= 1'b1;
              match   <= '0;
              locked  <= 1'b0;
              state   <= WAIT_REF;
              cnt     <= '0;
`ifdef PHASE_AVG_EN
              hist_n  <= '0;
`endif
            end else if (ref_rise) begin
              cnt <= CNT_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase

        if (res_valid) begin
          prev   <= res_val;
          match  <= match_nxt;
          locked <= (match_nxt >= LOCK_M);
`ifdef PHASE_AVG_EN
          // NOTE: history contents are never reset; hist_n gates every use.
          hist[0] <= res_val;
          hist[1] <= hist[0];
          hist[2] <= hist[1];
          if (hist_n == 2'd3) begin
            phase_cnt  <= avg;
            meas_valid <= 1'b1;
          end else begin
            hist_n <= hist_n + 2'd1;
          end
`else
          phase_cnt  <= res_val;
          meas_valid <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_phase_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_meter
//   Directed bench for clock_phase_meter. Stimulus tasks push the expected
//   report (value, lock level, cycle of appearance) into a queue; a monitor
//   on the falling edge pops and compares whenever meas_valid or timeout is
//   presented. Abort scenarios are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_clock_phase_meter;

  logic       clk = 1'b0;
  logic       reset, enable, ref_in, dly_in;
  logic [7:0] phase_cnt;
  logic       meas_valid, timeout, locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit tmo;
    int phase;
    bit lck;
    int cyc;
  } exp_t;

  exp_t q[$];

  clock_phase_meter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ref_in     (ref_in),
    .dly_in     (dly_in),
    .phase_cnt  (phase_cnt),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (meas_valid || timeout) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: mv=%0b to=%0b phase=%0d, nothing expected (cycle %0d)",
                 meas_valid, timeout, phase_cnt, cyc);
      end else begin
        e = q.pop_front();
        check("timeout_flag", int'(timeout), int'(e.tmo));
        check("meas_valid_flag", int'(meas_valid), int'(!e.tmo));
        check("phase_cnt", int'(phase_cnt), e.phase);
        check("locked", int'(locked), int'(e.lck));
        check("report_cycle", cyc, e.cyc);
      end
    end
  end

  // One ref period of 20 cycles, dly rising d cycles after ref (d <= 9).
  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic pulse(input int d, input int ph, input bit lck, input bit report);
    int t0;
    exp_t e;
    t0 = cyc;
    if (report) begin
      e.tmo = 1'b0; e.phase = ph; e.lck = lck; e.cyc = t0 + d + 1;
      q.push_back(e);
    end
    ref_in = 1'b1;
    if (d == 0) dly_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == d)      dly_in = 1'b1;
      if (i == 10)     ref_in = 1'b0;
      if (i == d + 10) dly_in = 1'b0;
    end
  endtask

  // Single ref edge with no dly edge: timeout expected at cnt == 200.
  task automatic no_dly(input int held_phase);
    int t0;
    exp_t e;
    t0 = cyc;
    e.tmo = 1'b1; e.phase = held_phase; e.lck = 1'b0; e.cyc = t0 + 201;
    q.push_back(e);
    ref_in = 1'b1;
    for (int i = 1; i <= 210; i++) begin
      @(posedge clk); #1;
      if (i == 10) ref_in = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs(input string tag, input int ph);
    @(negedge clk);
    check({tag, "_phase_cnt"}, int'(phase_cnt), ph);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_locked"}, int'(locked), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ref_in = 1'b0; dly_in = 1'b0;
    idle_cycles(2);
    check_outputs("reset", 0);
    reset = 1'b0;
    enable = 1'b1;
    idle_cycles(2);

`ifdef PHASE_AVG_EN
    // Averaged build: 4,4,4,8 -> first report 5; then 8 -> (4+4+8+8)/4 = 6.
    pulse(4, 0, 0, 0);
    pulse(4, 0, 0, 0);
    pulse(4, 0, 0, 0);
    pulse(8, 5, 0, 1);
    pulse(8, 6, 0, 1);
`else
    // Steady delay 3: lock on the 4th result.
    pulse(3, 3, 0, 1);
    pulse(3, 3, 0, 1);
    pulse(3, 3, 0, 1);
    pulse(3, 3, 1, 1);
    pulse(3, 3, 1, 1);
    // Jump to 6: lock drops at once, returns after 3 more results of 6.
    pulse(6, 6, 0, 1);
    pulse(6, 6, 0, 1);
    pulse(6, 6, 0, 1);
    pulse(6, 6, 1, 1);
    pulse(5, 5, 1, 1);
    // Coincident edges: zero delay, breaks lock.
    pulse(0, 0, 0, 1);
    pulse(3, 3, 0, 1);
    pulse(3, 3, 0, 1);
    pulse(3, 3, 0, 1);
    pulse(3, 3, 1, 1);
    // 3 -> 4 lies within tolerance: stays locked.
    pulse(4, 4, 1, 1);
    // No dly edge: timeout, phase_cnt held, lock lost.
    no_dly(4);
    pulse(2, 2, 0, 1);
    pulse(2, 2, 0, 1);
    pulse(2, 2, 0, 1);
    pulse(2, 2, 1, 1);

    // Reset in the middle of a COUNT.
    ref_in = 1'b1;
    idle_cycles(3);
    ref_in = 1'b0;
    reset  = 1'b1;
    idle_cycles(1);
    check_outputs("mid_reset", 0);
    reset = 1'b0;
    idle_cycles(2);
    pulse(7, 7, 0, 1);
    pulse(7, 7, 0, 1);
    pulse(7, 7, 0, 1);
    pulse(7, 7, 1, 1);

    // Disable in the middle of a COUNT: phase_cnt holds, lock cleared.
    ref_in = 1'b1;
    idle_cycles(3);
    ref_in = 1'b0;
    enable = 1'b0;
    idle_cycles(1);
    check_outputs("mid_disable", 7);
    dly_in = 1'b1;
    idle_cycles(3);
    dly_in = 1'b0;
    enable = 1'b1;
    idle_cycles(2);
    pulse(5, 5, 0, 1);
`endif

    idle_cycles(5);
    check("pending_reports", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
